// File: rtl/hall_pkg.sv
// hall_pkg: hall code table, sector stepping helpers and run-state type for the hall interface
package hall_pkg;
  typedef enum logic [1:0] {IDLE, RAMP, RUN} state_t;
  localparam logic [5:0][2:0] HALL_TABLE = {3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  function automatic logic [2:0] hall_code(input logic [2:0] s);
    return s > 3'd5 ? HALL_TABLE[0] : HALL_TABLE[s];
  endfunction
  function automatic logic [2:0] next_sector(input logic [2:0] s);
    return s >= 3'd5 ? 3'd0 : s + 3'd1;
  endfunction
  function automatic logic [2:0] prev_sector(input logic [2:0] s);
    return s == 3'd0 ? 3'd5 : s - 3'd1;
  endfunction
endpackage

// File: rtl/hall_step_timer.sv
// hall_step_timer: free-running step counter that strobes when the programmed period elapses
module hall_step_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active,
  input  logic                clr,
  input  logic [PERIOD_W-1:0] period,
  output logic                step
);
  logic [PERIOD_W-1:0] timer;
  assign step = active && timer == period - PERIOD_W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer <= '0;
    else timer <= (!active || clr || step) ? '0 : timer + PERIOD_W'(1);
endmodule

// File: rtl/hall_emulator.sv
// hall_emulator: synthesises BLDC hall codes with start-up ramp, direction and revolution count
module hall_emulator
  import hall_pkg::*;
#(
  parameter int PERIOD_W   = 16,
  parameter int RAMP_STEP  = 16,
  parameter int MIN_PERIOD = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] start_period,
  input  logic [PERIOD_W-1:0] target_period,
  output logic [2:0]          H,
  output logic [2:0]          sector,
  output logic                step_pulse,
  output logic                at_speed,
  output logic [15:0]         rev_count
);
  localparam logic [PERIOD_W-1:0] RS = PERIOD_W'(RAMP_STEP);
  localparam logic [PERIOD_W-1:0] MP = PERIOD_W'(MIN_PERIOD);
  state_t state;
  logic [PERIOD_W-1:0] cur, tgt, ld_tgt, ld_cur, ramp_cur;
  logic [2:0] nsec;
  logic [15:0] rev_delta;
  logic step;
  hall_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .active(state != IDLE),
    .clr   (!en),
    .period(cur),
    .step  (step)
  );
  always_comb begin
    ld_tgt    = target_period < MP ? MP : target_period;
    ld_cur    = start_period > ld_tgt ? start_period : ld_tgt;
    ramp_cur  = (cur - tgt > RS) ? cur - RS : tgt;
    nsec      = dir ? next_sector(sector) : prev_sector(sector);
    rev_delta = (dir && sector == 3'd5) ? 16'd1 : (!dir && sector == 3'd0) ? 16'hFFFF : 16'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cur        <= '0;
      tgt        <= '0;
      H          <= 3'b101;
      sector     <= 3'd0;
      step_pulse <= 1'b0;
      at_speed   <= 1'b0;
      rev_count  <= 16'd0;
    end else begin
      step_pulse <= step;
      if (step) begin
        sector    <= nsec;
        H         <= hall_code(nsec);
        rev_count <= rev_count + rev_delta;
      end
      // a step landing on the en=0 edge still completes above; only the state unwinds here
      case (state)
        IDLE: if (en) begin
          cur      <= ld_cur;
          tgt      <= ld_tgt;
          state    <= ld_cur > ld_tgt ? RAMP : RUN;
          at_speed <= ld_cur == ld_tgt;
        end
        RAMP: if (!en) begin
          state    <= IDLE;
          at_speed <= 1'b0;
        end else if (step) begin
          cur <= ramp_cur;
          if (ramp_cur == tgt) begin
            state    <= RUN;
            at_speed <= 1'b1;
          end
        end
        default: if (!en) begin
          state    <= IDLE;
          at_speed <= 1'b0;
        end
      endcase
    end
endmodule
